// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - press-driven parametrised up/down counter with wrap/saturate, load, clear
module updown_counter_param #(
  parameter int              WIDTH   = 16,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP    = 1,
  parameter bit              WRAP_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr,
  output logic [WIDTH-1:0] c_out,
  output logic             z,
  output logic             m,
  output logic             ovf,
  output logic             busy
);

  // All bound arithmetic is done one bit wider so c_out + STEP and
  // c_out + MAX_VAL + 1 never overflow before the comparison.
  localparam logic [WIDTH:0] MAX_X      = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X     = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] RANGE_X    = (WIDTH+1)'(MAX_VAL + 64'd1);
  localparam logic [WIDTH:0] DEC_WRAP_X = (WIDTH+1)'(MAX_VAL + 64'd1 - STEP);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INC      = 2'd1,
    DEC      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] inc_val;
  logic             inc_ovf;
  logic [WIDTH-1:0] dec_val;
  logic             dec_ovf;
  logic [WIDTH-1:0] load_val;

  // Candidate results of one up step, one down step and a clamped load.
  always_comb begin
    inc_sum = {1'b0, count_q} + STEP_X;
    inc_val = inc_sum[WIDTH-1:0];
    inc_ovf = 1'b0;
    if (inc_sum > MAX_X) begin
      inc_ovf = 1'b1;
      if (WRAP_EN) begin
        inc_val = WIDTH'(inc_sum - RANGE_X);
      end else begin
        inc_val = MAX_X[WIDTH-1:0];
      end
    end

    dec_val = WIDTH'({1'b0, count_q} - STEP_X);
    dec_ovf = 1'b0;
    if ({1'b0, count_q} < STEP_X) begin
      dec_ovf = 1'b1;
      if (WRAP_EN) begin
        dec_val = WIDTH'({1'b0, count_q} + DEC_WRAP_X);
      end else begin
        dec_val = '0;
      end
    end

    load_val = ld_val;
    if ({1'b0, ld_val} > MAX_X) begin
      load_val = MAX_X[WIDTH-1:0];
    end
  end

  // Press FSM and count update; clear overrides the count but not the state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          count_d = load_val;
        end else if (u && !d) begin
          state_d = INC;
        end else if (d && !u) begin
          state_d = DEC;
        end
      end
      INC: begin
        count_d = inc_val;
        ovf_d   = inc_ovf;
        state_d = WAIT_REL;
      end
      DEC: begin
        count_d = dec_val;
        ovf_d   = dec_ovf;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!u && !d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // State, count and ovf registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign c_out = count_q;
  assign z     = (count_q == '0);
  assign m     = (count_q == MAX_X[WIDTH-1:0]);
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE);

endmodule
